// File: rtl/ui_mem_pkg.sv
// ---------------------------------------------------------------------------
// ui_mem_pkg
// Purpose : shared constants and types for the UI memory model.
//   CMD_WRITE / CMD_READ : app_cmd encodings understood by the model.
//   wdf_entry_t          : one write-data FIFO entry (data + byte mask).
//                          Sized for the widest supported UI data bus;
//                          narrower buses use the low bits only.
// ---------------------------------------------------------------------------
package ui_mem_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int UI_MAX_DATA_W = 64;

    typedef struct packed {
        logic [UI_MAX_DATA_W-1:0]   data;
        logic [UI_MAX_DATA_W/8-1:0] mask;   // 1 = keep the old byte
    } wdf_entry_t;

endpackage

// File: rtl/ui_sync_fifo.sv
// ---------------------------------------------------------------------------
// ui_sync_fifo
// Purpose : small single-clock FIFO with a count-based full/empty.
// Ports   : clk_i, rst_ni (async, active-low)
//           push_i/data_i : write side, ignored when full unless popping
//           pop_i/data_o  : read side, data_o shows the head entry
//           full_o/empty_o: occupancy flags
// Push and pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module ui_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign data_o  = store_q[rptr_q];

    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed after being pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            store_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ui_mem_model.sv
// ---------------------------------------------------------------------------
// ui_mem_model
// Purpose : behavioural-but-synthesizable model of a memory controller user
//           interface. Write commands and write data are decoupled through
//           two FIFOs and committed to an internal array once both are
//           present; reads return after a fixed latency, in order.
// Ports   :
//   clk, rst (async, active-low)
//   app_en/app_cmd/app_addr/app_rdy       : command channel
//   app_wdf_wren/end/data/mask/app_wdf_rdy : write-data channel
//   app_rd_data_valid/app_rd_data/app_rd_data_end : read return
//   wr_count/rd_count : saturating completed-write / returned-read counts
//   protocol_err      : sticky protocol violation flag
// Handshake: a transfer happens on a rising edge where the valid
// (app_en / app_wdf_wren) and the matching ready are both high; the
// source holds its payload until then. Read returns have no backpressure.
// ---------------------------------------------------------------------------
module ui_mem_model
    import ui_mem_pkg::*;
#(
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_ADDR_WIDTH = 33,
    parameter int MEM_DEPTH_LOG  = 10,
    parameter int RD_LATENCY     = 8,
    parameter int RDY_PERIOD     = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        app_en,
    input  logic [2:0]                  app_cmd,
    input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
    output logic                        app_rdy,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_rdy,
    output logic                        app_rd_data_valid,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_end,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 rd_count,
    output logic                        protocol_err
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG;
    localparam int MW    = APP_DATA_WIDTH / 8;
    localparam int LAT   = RD_LATENCY;
    localparam int RP    = (RDY_PERIOD == 0) ? 1 : RDY_PERIOD;
    localparam logic [15:0] THR_LAST = 16'(RP - 1);

    typedef logic [MEM_DEPTH_LOG-1:0] idx_t;

    // Address bits outside the word index are ignored (aliasing by design).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app_addr[2:0], app_addr[APP_ADDR_WIDTH-1:3+MEM_DEPTH_LOG]};

    idx_t cmd_idx;
    assign cmd_idx = app_addr[3 +: MEM_DEPTH_LOG];

    // ---------------- command / data acceptance ----------------
    logic throttle;
    logic cmd_acc, wr_cmd_acc, rd_cmd_acc, bad_cmd_acc, data_acc;
    logic af_full, af_empty, df_full, df_empty, wr_commit;
    logic [15:0] thr_q, thr_d;

    assign throttle    = (RDY_PERIOD != 0) && (thr_q == THR_LAST);
    // A lone write address waiting for its data blocks further commands.
    assign app_rdy     = rst && !throttle && !af_full && !(!af_empty && df_empty);
    assign app_wdf_rdy = rst && !df_full;

    assign cmd_acc     = app_en && app_rdy;
    assign wr_cmd_acc  = cmd_acc && (app_cmd == CMD_WRITE);
    assign rd_cmd_acc  = cmd_acc && (app_cmd == CMD_READ);
    assign bad_cmd_acc = cmd_acc && !wr_cmd_acc && !rd_cmd_acc;
    assign data_acc    = app_wdf_wren && app_wdf_rdy;
    assign wr_commit   = !af_empty && !df_empty;

    assign thr_d = (thr_q == THR_LAST) ? '0 : thr_q + 16'd1;

    // ---------------- write FIFOs ----------------
    wdf_entry_t wdf_in, wdf_head;
    idx_t       widx;

    always_comb begin
        wdf_in = '0;
        wdf_in.data[APP_DATA_WIDTH-1:0] = app_wdf_data;
        wdf_in.mask[MW-1:0]             = app_wdf_mask;
    end

    ui_sync_fifo #(
        .WIDTH (MEM_DEPTH_LOG),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (wr_cmd_acc),
        .data_i  (cmd_idx),
        .pop_i   (wr_commit),
        .data_o  (widx),
        .full_o  (af_full),
        .empty_o (af_empty)
    );

    ui_sync_fifo #(
        .WIDTH ($bits(wdf_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (data_acc),
        .data_i  (wdf_in),
        .pop_i   (wr_commit),
        .data_o  (wdf_head),
        .full_o  (df_full),
        .empty_o (df_empty)
    );

    // ---------------- storage ----------------
    logic [APP_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]          written_q;
    logic [APP_DATA_WIDTH-1:0] wdata;
    logic [MW-1:0]             wmask;

    assign wdata = wdf_head.data[APP_DATA_WIDTH-1:0];
    assign wmask = wdf_head.mask[MW-1:0];

    // Masked bytes of a never-written word read back as zero, so they are
    // cleared on the first write instead of inheriting power-up contents.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < MW; b++) begin
                if (!wmask[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end else if (!written_q[widx]) begin
                    mem_q[widx][8*b +: 8] <= 8'h00;
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // The array is sampled from the last pipeline stage, at least one edge
    // after acceptance, so any write completed by the read's acceptance edge
    // has already been committed (a paired write commits on the next edge).
    logic [LAT-1:0]            rv_q;
    idx_t                      ridx_q [LAT];
    logic [APP_DATA_WIDTH-1:0] rd_word;

    assign rd_word = written_q[ridx_q[LAT-1]] ? mem_q[ridx_q[LAT-1]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q             <= '0;
            written_q         <= '0;
            rv_q              <= '0;
            for (int i = 0; i < LAT; i++) begin
                ridx_q[i] <= '0;
            end
            app_rd_data_valid <= 1'b0;
            app_rd_data_end   <= 1'b0;
            app_rd_data       <= '0;
            wr_count          <= '0;
            rd_count          <= '0;
            protocol_err      <= 1'b0;
        end else begin
            thr_q <= thr_d;
            if (wr_commit) begin
                written_q[widx] <= 1'b1;
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
            rv_q      <= {rv_q[LAT-2:0], rd_cmd_acc};
            ridx_q[0] <= cmd_idx;
            for (int i = 1; i < LAT; i++) begin
                ridx_q[i] <= ridx_q[i-1];
            end
            app_rd_data_valid <= rv_q[LAT-1];
            app_rd_data_end   <= rv_q[LAT-1];
            if (rv_q[LAT-1]) begin
                app_rd_data <= rd_word;
                if (rd_count != 16'hFFFF) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
            if (bad_cmd_acc || (app_wdf_wren && !app_wdf_end)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ui_mem_model.md
UI_MEM_MODEL -- requirements
Module: ui_mem_model

Interface
REQ-001 Parameters (name, default, meaning): APP_DATA_WIDTH, 64, UI data width; APP_ADDR_WIDTH, 33, UI address width; MEM_DEPTH_LOG, 10, log2 of stored bursts; RD_LATENCY, 8, read-command-accept to data-valid cycles (min 2); RDY_PERIOD, 16, app_rdy throttle period (0 = no throttle); FIFO_DEPTH, 4, write command/data FIFO depth.
REQ-002 Ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-low; app_en in 1 command valid; app_cmd in 3 command (0 write, 1 read); app_addr in APP_ADDR_WIDTH burst address; app_rdy out 1 command ready; app_wdf_wren in 1 write data valid; app_wdf_end in 1 burst end; app_wdf_data in APP_DATA_WIDTH write data; app_wdf_mask in APP_DATA_WIDTH/8 byte mask, 1 = keep old byte; app_wdf_rdy out 1 write data ready; app_rd_data_valid out 1; app_rd_data out APP_DATA_WIDTH; app_rd_data_end out 1; wr_count out 16 completed writes; rd_count out 16 returned reads; protocol_err out 1 sticky error.

Function
REQ-003 Command accepted when app_en && app_rdy; write data accepted when app_wdf_wren && app_wdf_rdy; no other condition accepts either.
REQ-004 Memory index = app_addr[3 +: MEM_DEPTH_LOG]; bits [2:0] and bits above the index are ignored (aliasing/wrap-around, no error).
REQ-005 Accepted write command pushes its index into write-address FIFO; accepted write data pushes data+mask into write-data FIFO; both may occur in the same cycle or in either order.
REQ-006 When both FIFOs are non-empty, one entry of each is popped and written to memory on that same edge, mask applied per byte; wr_count increments by 1.
REQ-007 Throttle: free-running counter modulo RDY_PERIOD; throttle is high in the cycle the counter equals RDY_PERIOD-1.
REQ-008 app_rdy = !throttle && !addr_fifo_full && !(addr_fifo non-empty && data_fifo empty).
REQ-009 app_wdf_rdy = !data_fifo_full; unaffected by throttle.
REQ-010 Read accepted at edge N returns the stored word (0 for never-written words) with app_rd_data_valid=app_rd_data_end=1 for exactly one cycle, registered so it is visible after edge N+RD_LATENCY; rd_count increments on that edge.
REQ-011 Reads return in acceptance order; back-to-back reads produce back-to-back valid cycles; no read backpressure.
REQ-012 Ordering: a read sees every write whose command and data were both accepted at or before the read's acceptance edge (write-first on same-edge collision).
REQ-013 app_rd_data holds its last value when app_rd_data_valid=0.
REQ-014 protocol_err sets (sticky until reset) on: accepted command with app_cmd not 0/1 (command dropped); app_wdf_wren=1 with app_wdf_end=0.
REQ-015 wr_count and rd_count saturate at 16'hFFFF.

Reset
REQ-016 While rst=0: app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, counters=0, protocol_err=0, both FIFOs empty, throttle counter=0, per-word written flags cleared, read pipeline flushed; app_rdy and app_wdf_rdy are 0 during reset.
REQ-017 Reset asserted mid-operation discards pending writes and in-flight reads; no valid is emitted for them after release.
REQ-018 First edge after release: app_wdf_rdy=1; app_rdy=1 unless throttle.

Structure
REQ-019 Package ui_mem_pkg holds CMD_WRITE=3'b000, CMD_READ=3'b001 and the write-data FIFO entry typedef (data+mask).
REQ-020 One sub-module ui_sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop), instantiated twice.

Verification
REQ-021 Write addr 0x0 data 0x0000_0000_8000_0000 mask 0, then read 0x0 -> valid exactly RD_LATENCY cycles after accept, data 0x0000_0000_8000_0000, wr_count=1, rd_count=1.
REQ-022 Write addr 0x8 data 0x0; write addr 0x8 data 0xFFFF_FFFF_FFFF_FFFF mask 0x0F; read 0x8 -> 0xFFFF_FFFF_0000_0000.
REQ-023 Write command at 0x10 with data withheld 3 cycles -> app_rdy=0 for those cycles; data arrives -> memory written, app_rdy returns 1 next cycle.
REQ-024 Write at 0x0 then 0x2000 (aliases index 0 with MEM_DEPTH_LOG=10), read 0x0 -> second write's data; read never-written 0x18 -> 0.
REQ-025 Issue 8 back-to-back reads with RDY_PERIOD=4 -> app_rdy low every 4th cycle, 8 valid pulses in order, rd_count=8.
REQ-026 Assert rst with 3 reads in flight -> no further valid pulses after release, counters 0; app_cmd=3'b010 accepted -> protocol_err=1 and stays 1.
